// File: rtl/pipeline_ctrl.sv
// Central sequencer for the 5-stage pipeline: latch enables/flushes, PC enable,
// dcache-wait / halt-drain / halted states and saturating stall/flush counters.
//
// Latch control semantics: an x_en of 1 loads the latch; x_flush=1 (only
// meaningful with x_en=1) loads a bubble instead of the upstream stage.
module pipeline_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dmemREN_mem,
  input  logic             dmemWEN_mem,
  input  logic             memToReg_ex,
  input  logic [4:0]       rt_ex,
  input  logic [4:0]       rs_id,
  input  logic [4:0]       rt_id,
  input  logic             branch_taken,
  input  logic             halt_mem,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    DRAIN   = 2'd2,
    HALTED  = 2'd3
  } state_t;

  state_t state, next_state;
  logic   dmem_req, load_use, stall_inc, flush_inc;

  assign dmem_req  = (dmemREN_mem | dmemWEN_mem) & ~dhit;
  assign load_use  = memToReg_ex & (rt_ex != 5'd0) &
                     ((rt_ex == rs_id) | (rt_ex == rt_id));
  assign state_dbg = state;

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= RUN;
    else     state <= next_state;
  end

  // Next-state selection
  always_comb begin
    next_state = state;
    case (state)
      RUN: begin
        if (dmem_req)      next_state = MEMWAIT;
        else if (halt_mem) next_state = DRAIN;
      end
      MEMWAIT: if (dhit) next_state = RUN;
      DRAIN:   next_state = HALTED;
      HALTED:  next_state = HALTED;
      default: next_state = RUN;
    endcase
  end

  // Latch enables/flushes and counter increment strobes
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    flush_inc   = 1'b0;
    case (state)
      RUN, MEMWAIT: begin
        if ((state == RUN && dmem_req) || (state == MEMWAIT && !dhit)) begin
          // Outstanding dcache miss: freeze the whole pipe
          pc_en    = 1'b0;
          ifid_en  = 1'b0;
          idex_en  = 1'b0;
          exmem_en = 1'b0;
          memwb_en = 1'b0;
        end else if (state == RUN && halt_mem) begin
          // Squash younger instrs; halt itself moves on to WB
          pc_en       = 1'b0;
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
        end else if (branch_taken) begin
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
          flush_inc   = 1'b1;
        end else if (load_use) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end else if (!ihit) begin
          pc_en      = 1'b0;
          ifid_flush = 1'b1;
        end
      end
      DRAIN: begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        exmem_en = 1'b0;
      end
      default: begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        exmem_en = 1'b0;
        memwb_en = 1'b0;
      end
    endcase
  end

  assign stall_inc = ((state == RUN) || (state == MEMWAIT)) && !pc_en;

  // Halt flag rises on the DRAIN->HALTED edge and stays until reset
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) halt <= 1'b0;
    else     halt <= (state == DRAIN) || (state == HALTED);
  end

  // Saturating performance counters
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + 1'b1;
      if (flush_inc && (flush_cnt != {CNT_W{1'b1}})) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl. A second narrow-counter instance shares the
// inputs so counter saturation is reachable in a few cycles.
module tb_pipeline_ctrl;

  logic       CLK, RST;
  logic       ihit, dhit, dmemREN_mem, dmemWEN_mem, memToReg_ex;
  logic [4:0] rt_ex, rs_id, rt_id;
  logic       branch_taken, halt_mem;

  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush, exmem_flush, memwb_flush, halt;
  logic [31:0] stall_cnt, flush_cnt;
  logic [1:0]  state_dbg;

  logic        s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en;
  logic        s_ifid_flush, s_idex_flush, s_exmem_flush, s_memwb_flush, s_halt;
  logic [2:0]  s_stall_cnt, s_flush_cnt;
  logic [1:0]  s_state_dbg;

  logic [8:0] ctrl;
  assign ctrl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                 ifid_flush, idex_flush, exmem_flush, memwb_flush};

  // {pc, ifid_en, idex_en, exmem_en, memwb_en, ifid_fl, idex_fl, exmem_fl, memwb_fl}
  localparam logic [8:0] ALL_EN = 9'b1_1111_0000;
  localparam logic [8:0] HOLD   = 9'b0_0000_0000;
  localparam logic [8:0] LU     = 9'b0_0111_0100;
  localparam logic [8:0] NOIHIT = 9'b0_1111_1000;
  localparam logic [8:0] BR     = 9'b1_1111_1110;
  localparam logic [8:0] HALTC  = 9'b0_1111_1110;
  localparam logic [8:0] DRAINC = 9'b0_0001_0000;

  int n_tests = 0;
  int n_fail  = 0;
  logic [8:0] exp_q[$];

  pipeline_ctrl #(.CNT_W(32)) u_dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .dmemREN_mem(dmemREN_mem), .dmemWEN_mem(dmemWEN_mem),
    .memToReg_ex(memToReg_ex), .rt_ex(rt_ex), .rs_id(rs_id), .rt_id(rt_id),
    .branch_taken(branch_taken), .halt_mem(halt_mem),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .memwb_flush(memwb_flush), .halt(halt),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .state_dbg(state_dbg)
  );

  pipeline_ctrl #(.CNT_W(3)) u_sat (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .dmemREN_mem(dmemREN_mem), .dmemWEN_mem(dmemWEN_mem),
    .memToReg_ex(memToReg_ex), .rt_ex(rt_ex), .rs_id(rs_id), .rt_id(rt_id),
    .branch_taken(branch_taken), .halt_mem(halt_mem),
    .pc_en(s_pc_en), .ifid_en(s_ifid_en), .idex_en(s_idex_en), .exmem_en(s_exmem_en),
    .memwb_en(s_memwb_en), .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush),
    .exmem_flush(s_exmem_flush), .memwb_flush(s_memwb_flush), .halt(s_halt),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt), .state_dbg(s_state_dbg)
  );

  // Clock/reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs at negedge, then compare latch controls
  task automatic drive(input string tag, input logic ih, input logic dh,
                       input logic rn, input logic wn, input logic m2r,
                       input logic [4:0] rte, input logic [4:0] rs, input logic [4:0] rt,
                       input logic br, input logic hm, input logic [8:0] exp_ctrl);
    @(negedge CLK);
    ihit = ih; dhit = dh; dmemREN_mem = rn; dmemWEN_mem = wn; memToReg_ex = m2r;
    rt_ex = rte; rs_id = rs; rt_id = rt; branch_taken = br; halt_mem = hm;
    exp_q.push_back(exp_ctrl);
    #1;
    check({tag, ".ctrl"}, {23'd0, ctrl}, {23'd0, exp_q.pop_front()});
  endtask

  task automatic idle(input string tag, input logic [8:0] exp_ctrl);
    drive(tag, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, exp_ctrl);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    ihit = 1; dhit = 0; dmemREN_mem = 0; dmemWEN_mem = 0; memToReg_ex = 0;
    rt_ex = 0; rs_id = 0; rt_id = 0; branch_taken = 0; halt_mem = 0;
    RST = 1'b1;
    #1;
    check("rst.state", {30'd0, state_dbg}, 32'd0);
    check("rst.halt", {31'd0, halt}, 32'd0);
    check("rst.stall", stall_cnt, 32'd0);
    check("rst.flush", flush_cnt, 32'd0);
    do_reset();

    idle("idle", ALL_EN);
    check("idle.stall", stall_cnt, 32'd0);
    // dcache hit in RUN: no stall
    drive("dhit_run", 1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, ALL_EN);
    // dcache miss for 3 cycles, released on 4th
    drive("miss0", 1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, HOLD);
    drive("miss1", 1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, HOLD);
    check("miss1.state", {30'd0, state_dbg}, 32'd1);
    drive("miss2", 1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, HOLD);
    drive("miss_rel", 1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, ALL_EN);
    check("miss.stall", stall_cnt, 32'd3);
    // Load-use on rs, then rt_ex=0 never stalls
    drive("lu_rs", 1, 0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 0, 0, LU);
    drive("lu_r0", 1, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0, 0, ALL_EN);
    check("lu.stall", stall_cnt, 32'd4);
    drive("lu_rt", 1, 0, 0, 0, 1, 5'd7, 5'd3, 5'd7, 0, 0, LU);
    drive("lu_none", 1, 0, 0, 0, 1, 5'd7, 5'd3, 5'd4, 0, 0, ALL_EN);
    check("lu2.stall", stall_cnt, 32'd5);
    drive("noihit", 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, NOIHIT);
    // Branch outranks load-use and icache miss
    drive("br_prio", 0, 0, 0, 0, 1, 5'd9, 5'd9, 5'd0, 1, 0, BR);
    idle("post_br", ALL_EN);
    check("br.stall", stall_cnt, 32'd6);
    check("br.flush", flush_cnt, 32'd1);
    check("sat.stall6", {29'd0, s_stall_cnt}, 32'd6);
    // Miss released while icache misses
    drive("miss_b", 1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, HOLD);
    drive("rel_noihit", 0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, NOIHIT);
    check("rel.state", {30'd0, state_dbg}, 32'd1);
    check("sat.stall7", {29'd0, s_stall_cnt}, 32'd7);
    idle("post_rel", ALL_EN);
    check("rel.run", {30'd0, state_dbg}, 32'd0);
    check("rel.stall", stall_cnt, 32'd8);
    check("sat.hold", {29'd0, s_stall_cnt}, 32'd7);
    // Halt: drain one cycle, then halted ignoring inputs
    drive("halt_mem", 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, HALTC);
    drive("drain", 0, 0, 1, 0, 1, 5'd3, 5'd3, 5'd3, 1, 1, DRAINC);
    check("drain.state", {30'd0, state_dbg}, 32'd2);
    check("drain.halt", {31'd0, halt}, 32'd0);
    check("drain.stall", stall_cnt, 32'd9);
    drive("halted0", 0, 0, 1, 0, 1, 5'd3, 5'd3, 5'd3, 1, 1, HOLD);
    check("halted.state", {30'd0, state_dbg}, 32'd3);
    check("halted.halt", {31'd0, halt}, 32'd1);
    drive("halted1", 1, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 1, 0, HOLD);
    check("halted.stall", stall_cnt, 32'd9);
    check("halted.flush", flush_cnt, 32'd1);
    check("sat.final", {29'd0, s_stall_cnt}, 32'd7);

    // Reset asserted mid-DRAIN returns to RUN at once
    do_reset();
    drive("halt2", 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, HALTC);
    idle("drain2", DRAINC);
    check("drain2.stall", stall_cnt, 32'd1);
    RST = 1'b1;
    #1;
    check("rstd.state", {30'd0, state_dbg}, 32'd0);
    check("rstd.halt", {31'd0, halt}, 32'd0);
    check("rstd.stall", stall_cnt, 32'd0);
    check("rstd.flush", flush_cnt, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    idle("after_rst", ALL_EN);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
